// File: rtl/axis_spm_scan_transform.sv
// axis_spm_scan_transform: rotates scan-relative XY into absolute coordinates,
// applies rate-limited absolute offsets and optional plane-slope correction to Z,
// and streams saturated X/Y/Z/U words to the DAC and monitor AXI-Stream channels.
// Optional feature macro: SPM_SCAN_TRANSFORM_SLOPE_EN (slope multipliers in S4).
module axis_spm_scan_transform #(
  parameter int unsigned DW     = 32,
  parameter int unsigned QROTM  = 28,
  parameter int unsigned QSLOPE = 24,
  parameter int unsigned RDECI  = 4
) (
  input  logic                 a_clk,
  input  logic                 a_resetn,
  input  logic signed [DW-1:0] xs,
  input  logic signed [DW-1:0] ys,
  input  logic signed [DW-1:0] zs,
  input  logic signed [DW-1:0] u,
  input  logic signed [DW-1:0] rotmxx,
  input  logic signed [DW-1:0] rotmxy,
  input  logic signed [DW-1:0] slope_x,
  input  logic signed [DW-1:0] slope_y,
  input  logic signed [DW-1:0] x0,
  input  logic signed [DW-1:0] y0,
  input  logic signed [DW-1:0] z0,
  input  logic        [DW-1:0] offset_slew,
  input  logic signed [DW-1:0] S_AXIS_Z_tdata,
  input  logic                 S_AXIS_Z_tvalid,
  output logic signed [DW-1:0] M_AXIS1_tdata,
  output logic                 M_AXIS1_tvalid,
  output logic signed [DW-1:0] M_AXIS2_tdata,
  output logic                 M_AXIS2_tvalid,
  output logic signed [DW-1:0] M_AXIS3_tdata,
  output logic                 M_AXIS3_tvalid,
  output logic signed [DW-1:0] M_AXIS4_tdata,
  output logic                 M_AXIS4_tvalid,
  output logic signed [DW-1:0] M_AXIS_XMON_tdata,
  output logic                 M_AXIS_XMON_tvalid,
  output logic signed [DW-1:0] M_AXIS_YMON_tdata,
  output logic                 M_AXIS_YMON_tvalid,
  output logic signed [DW-1:0] M_AXIS_ZMON_tdata,
  output logic                 M_AXIS_ZMON_tvalid,
  output logic signed [DW-1:0] M_AXIS_UMON_tdata,
  output logic                 M_AXIS_UMON_tvalid,
  output logic                 offset_busy
);

  localparam int unsigned PW = 2 * DW + 1;  // rotation product / sum width
  localparam int unsigned ZW = DW + 4;      // Z summation width

  typedef logic signed [DW-1:0] word_t;
  typedef logic signed [PW-1:0] prod_t;

  typedef struct packed {
    word_t x, y, zs, u, mxx, mxy, sx, sy, zsrv, x0, y0, z0;
  } s1_t;
  typedef struct packed {
    prod_t rrx, rry;
    word_t zs, u, sx, sy, zsrv, x0, y0, z0;
  } s2_t;
  typedef struct packed {
    word_t xr, yr, zs, u, sx, sy, zsrv, x0, y0, z0;
  } s3_t;
  typedef struct packed {
    word_t x, y, zsl, zs, u, zsrv, z0;
  } s4_t;
  typedef struct packed {
    word_t x, y, z, u;
  } s5_t;

  // Symmetric saturation limits; the most negative code is never produced.
  localparam prod_t SAT_MAX = {{(DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam prod_t SAT_MIN = -SAT_MAX;

  function automatic word_t sat(input prod_t v);
    if (v > SAT_MAX) return DW'(SAT_MAX);
    else if (v < SAT_MIN) return DW'(SAT_MIN);
    else return DW'(v);
  endfunction

  // One slew step of working value o toward target t, bounded by s (0 = jump).
  function automatic word_t slew_step(input word_t o, input word_t t, input logic [DW-1:0] s);
    logic signed [DW:0] d;
    logic        [DW:0] mag;
    d   = (DW + 1)'(t) - (DW + 1)'(o);
    mag = d[DW] ? -d : d;
    if (s == '0 || mag <= {1'b0, s}) return t;
    else if (d[DW]) return o - $signed(s);
    else return o + $signed(s);
  endfunction

  logic [RDECI-1:0] cnt_q, cnt_d;
  logic [3:0]       en_q, en_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  word_t            zsrv_q, zsrv_d;
  word_t            ow_q [3];
  word_t            ow_d [3];
  word_t            tgt_c [3];
  logic             tick_c;
  word_t            zsl_c;
  logic signed [ZW-1:0] zsum_c;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;
  s4_t s4_q, s4_d;
  s5_t s5_q, s5_d;

  assign tick_c   = &cnt_q;
  assign tgt_c[0] = x0;
  assign tgt_c[1] = y0;
  assign tgt_c[2] = z0;

  // Tick counter, stage-enable shift, output-valid latch, Z-servo capture, busy flag.
  always_comb begin
    cnt_d   = cnt_q + RDECI'(1);
    en_d    = {en_q[2:0], tick_c};
    valid_d = valid_q | en_q[3];
    zsrv_d  = S_AXIS_Z_tvalid ? S_AXIS_Z_tdata : zsrv_q;
    busy_d  = (ow_q[0] != x0) | (ow_q[1] != y0) | (ow_q[2] != z0);
  end

  // Working offsets step toward their targets once per tick.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ow_d[i] = tick_c ? slew_step(ow_q[i], tgt_c[i], offset_slew) : ow_q[i];
    end
  end

  // S1: sample inputs and the pre-update working offsets on the tick.
  always_comb begin
    s1_d = s1_q;
    if (tick_c) begin
      s1_d.x    = xs;
      s1_d.y    = ys;
      s1_d.zs   = zs;
      s1_d.u    = u;
      s1_d.mxx  = rotmxx;
      s1_d.mxy  = rotmxy;
      s1_d.sx   = slope_x;
      s1_d.sy   = slope_y;
      s1_d.zsrv = zsrv_q;
      s1_d.x0   = ow_q[0];
      s1_d.y0   = ow_q[1];
      s1_d.z0   = ow_q[2];
    end
  end

  // S2: full-precision rotation products.
  always_comb begin
    s2_d = s2_q;
    if (en_q[0]) begin
      s2_d.rrx  = PW'($signed(s1_q.mxx)) * PW'($signed(s1_q.x))
                + PW'($signed(s1_q.mxy)) * PW'($signed(s1_q.y));
      s2_d.rry  = PW'($signed(s1_q.mxx)) * PW'($signed(s1_q.y))
                - PW'($signed(s1_q.mxy)) * PW'($signed(s1_q.x));
      s2_d.zs   = s1_q.zs;
      s2_d.u    = s1_q.u;
      s2_d.sx   = s1_q.sx;
      s2_d.sy   = s1_q.sy;
      s2_d.zsrv = s1_q.zsrv;
      s2_d.x0   = s1_q.x0;
      s2_d.y0   = s1_q.y0;
      s2_d.z0   = s1_q.z0;
    end
  end

  // S3: rescale rotated vector back to word width.
  always_comb begin
    s3_d = s3_q;
    if (en_q[1]) begin
      s3_d.xr   = sat($signed(s2_q.rrx) >>> QROTM);
      s3_d.yr   = sat($signed(s2_q.rry) >>> QROTM);
      s3_d.zs   = s2_q.zs;
      s3_d.u    = s2_q.u;
      s3_d.sx   = s2_q.sx;
      s3_d.sy   = s2_q.sy;
      s3_d.zsrv = s2_q.zsrv;
      s3_d.x0   = s2_q.x0;
      s3_d.y0   = s2_q.y0;
      s3_d.z0   = s2_q.z0;
    end
  end

`ifdef SPM_SCAN_TRANSFORM_SLOPE_EN
  // Plane-slope Z correction from the rotated XY.
  always_comb begin
    zsl_c = sat((PW'($signed(s3_q.sx)) * PW'($signed(s3_q.xr))
               + PW'($signed(s3_q.sy)) * PW'($signed(s3_q.yr))) >>> QSLOPE);
  end
`else
  logic unused_slope;
  assign zsl_c        = '0;
  assign unused_slope = ^{s3_q.sx, s3_q.sy, DW'(QSLOPE)};
`endif

  // S4: add XY offsets, carry slope correction.
  always_comb begin
    s4_d = s4_q;
    if (en_q[2]) begin
      s4_d.x    = sat(PW'($signed(s3_q.xr)) + PW'($signed(s3_q.x0)));
      s4_d.y    = sat(PW'($signed(s3_q.yr)) + PW'($signed(s3_q.y0)));
      s4_d.zsl  = zsl_c;
      s4_d.zs   = s3_q.zs;
      s4_d.u    = s3_q.u;
      s4_d.zsrv = s3_q.zsrv;
      s4_d.z0   = s3_q.z0;
    end
  end

  // S5: Z sum with headroom, then output saturation.
  always_comb begin
    zsum_c = ZW'($signed(s4_q.z0)) + ZW'($signed(s4_q.zs))
           + ZW'($signed(s4_q.zsl)) + ZW'($signed(s4_q.zsrv));
    s5_d = s5_q;
    if (en_q[3]) begin
      s5_d.x = s4_q.x;
      s5_d.y = s4_q.y;
      s5_d.z = sat(PW'(zsum_c));
      s5_d.u = s4_q.u;
    end
  end

  // State registers.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      cnt_q   <= '0;
      en_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      zsrv_q  <= '0;
      for (int i = 0; i < 3; i++) ow_q[i] <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      s4_q    <= '0;
      s5_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      zsrv_q  <= zsrv_d;
      for (int i = 0; i < 3; i++) ow_q[i] <= ow_d[i];
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      s4_q    <= s4_d;
      s5_q    <= s5_d;
    end
  end

  assign M_AXIS1_tdata      = s5_q.x;
  assign M_AXIS2_tdata      = s5_q.y;
  assign M_AXIS3_tdata      = s5_q.z;
  assign M_AXIS4_tdata      = s5_q.u;
  assign M_AXIS_XMON_tdata  = s5_q.x;
  assign M_AXIS_YMON_tdata  = s5_q.y;
  assign M_AXIS_ZMON_tdata  = s5_q.z;
  assign M_AXIS_UMON_tdata  = s5_q.u;
  assign M_AXIS1_tvalid     = valid_q;
  assign M_AXIS2_tvalid     = valid_q;
  assign M_AXIS3_tvalid     = valid_q;
  assign M_AXIS4_tvalid     = valid_q;
  assign M_AXIS_XMON_tvalid = valid_q;
  assign M_AXIS_YMON_tvalid = valid_q;
  assign M_AXIS_ZMON_tvalid = valid_q;
  assign M_AXIS_UMON_tvalid = valid_q;
  assign offset_busy        = busy_q;

endmodule

// File: tb/tb_axis_spm_scan_transform.sv
// Self-checking bench for axis_spm_scan_transform: directed cases plus random
// vectors compared against a transaction-level model of rotation, offsets and Z.
module tb_axis_spm_scan_transform;
  localparam int unsigned DW     = 32;
  localparam int unsigned QROTM  = 28;
  localparam int unsigned QSLOPE = 24;
  localparam int unsigned RDECI  = 4;

  logic a_clk = 1'b0;
  logic a_resetn = 1'b0;
  logic signed [DW-1:0] xs, ys, zs, u, rotmxx, rotmxy, slope_x, slope_y, x0, y0, z0;
  logic        [DW-1:0] offset_slew;
  logic signed [DW-1:0] s_z_tdata;
  logic                 s_z_tvalid;
  logic signed [DW-1:0] m1_d, m2_d, m3_d, m4_d, mx_d, my_d, mz_d, mu_d;
  logic m1_v, m2_v, m3_v, m4_v, mx_v, my_v, mz_v, mu_v;
  logic busy;

  int tests = 0;
  int fails = 0;

  // Reference state: working offsets, held Z-servo value, current expected outputs.
  longint ow [3];
  longint zsrv_m;
  longint ex, ey, ez, eu;
  logic   ev, eb;
  logic [RDECI-1:0] tcnt;

  axis_spm_scan_transform #(.DW(DW), .QROTM(QROTM), .QSLOPE(QSLOPE), .RDECI(RDECI)) dut (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .xs(xs), .ys(ys), .zs(zs), .u(u),
    .rotmxx(rotmxx), .rotmxy(rotmxy), .slope_x(slope_x), .slope_y(slope_y),
    .x0(x0), .y0(y0), .z0(z0), .offset_slew(offset_slew),
    .S_AXIS_Z_tdata(s_z_tdata), .S_AXIS_Z_tvalid(s_z_tvalid),
    .M_AXIS1_tdata(m1_d), .M_AXIS1_tvalid(m1_v),
    .M_AXIS2_tdata(m2_d), .M_AXIS2_tvalid(m2_v),
    .M_AXIS3_tdata(m3_d), .M_AXIS3_tvalid(m3_v),
    .M_AXIS4_tdata(m4_d), .M_AXIS4_tvalid(m4_v),
    .M_AXIS_XMON_tdata(mx_d), .M_AXIS_XMON_tvalid(mx_v),
    .M_AXIS_YMON_tdata(my_d), .M_AXIS_YMON_tvalid(my_v),
    .M_AXIS_ZMON_tdata(mz_d), .M_AXIS_ZMON_tvalid(mz_v),
    .M_AXIS_UMON_tdata(mu_d), .M_AXIS_UMON_tvalid(mu_v),
    .offset_busy(busy)
  );

  always #5 a_clk = ~a_clk;

  // Bench's own decimation phase: the tick cycle is when this reads all-ones.
  always @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) tcnt <= '0;
    else tcnt <= tcnt + RDECI'(1);
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint msat(input logic signed [127:0] v);
    logic signed [127:0] lim;
    lim = (128'sd1 <<< (DW - 1)) - 128'sd1;
    if (v > lim) return longint'(lim);
    if (v < -lim) return longint'(-lim);
    return longint'(v);
  endfunction

  function automatic longint tgt(input int i);
    if (i == 0) return longint'(x0);
    if (i == 1) return longint'(y0);
    return longint'(z0);
  endfunction

  // One decimated update: outputs from current inputs and pre-update offsets, then slew.
  task automatic model_tick();
    logic signed [127:0] xr, yr, zsl;
    longint d, ad, sl, t;
    xr = msat((128'(rotmxx) * 128'(xs) + 128'(rotmxy) * 128'(ys)) >>> QROTM);
    yr = msat((128'(rotmxx) * 128'(ys) - 128'(rotmxy) * 128'(xs)) >>> QROTM);
`ifdef SPM_SCAN_TRANSFORM_SLOPE_EN
    zsl = msat((128'(slope_x) * xr + 128'(slope_y) * yr) >>> QSLOPE);
`else
    zsl = 0;
`endif
    ex = msat(xr + 128'(ow[0]));
    ey = msat(yr + 128'(ow[1]));
    ez = msat(128'(ow[2]) + 128'(zs) + zsl + 128'(zsrv_m));
    eu = longint'(u);
    ev = 1'b1;
    sl = longint'({32'b0, offset_slew});
    eb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t  = tgt(i);
      d  = t - ow[i];
      ad = (d < 0) ? -d : d;
      if (sl == 0 || ad <= sl) ow[i] = t;
      else ow[i] = ow[i] + ((d < 0) ? -sl : sl);
      if (ow[i] != t) eb = 1'b1;
    end
  endtask

  task automatic set_z(input logic signed [DW-1:0] data, input logic valid);
    s_z_tdata  = data;
    s_z_tvalid = valid;
    if (valid) zsrv_m = longint'(data);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) ow[i] = 0;
    ex = 0; ey = 0; ez = 0; eu = 0; ev = 1'b0; eb = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"}, m1_d, 0);   check({tag, "_y"}, m2_d, 0);
    check({tag, "_z"}, m3_d, 0);   check({tag, "_u"}, m4_d, 0);
    check({tag, "_xm"}, mx_d, 0);  check({tag, "_ym"}, my_d, 0);
    check({tag, "_zm"}, mz_d, 0);  check({tag, "_um"}, mu_d, 0);
    check({tag, "_valid"}, {m1_v, m2_v, m3_v, m4_v, mx_v, my_v, mz_v, mu_v}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Wait for the next tick, step the model, check old outputs at T+4 and new at T+5.
  task automatic run_tick(input string tag);
    longint px, pz;
    logic   pv;
    int     guard;
    px = ex; pz = ez; pv = ev;
    @(negedge a_clk);
    guard = 0;
    while (tcnt != {RDECI{1'b1}} && guard < 40) begin
      @(negedge a_clk);
      guard++;
    end
    check({tag, "_tick_found"}, guard < 40, 1);
    model_tick();
    repeat (4) @(posedge a_clk);
    #1;
    check({tag, "_x_t4"}, m1_d, px);
    check({tag, "_z_t4"}, m3_d, pz);
    check({tag, "_v_t4"}, m1_v, pv);
    @(posedge a_clk);
    #1;
    check({tag, "_x"}, m1_d, ex);
    check({tag, "_y"}, m2_d, ey);
    check({tag, "_z"}, m3_d, ez);
    check({tag, "_u"}, m4_d, eu);
    check({tag, "_mon"}, {mx_d, my_d, mz_d, mu_d}, {m1_d === 32'(ex) ? m1_d : ~m1_d, 32'(ey), 32'(ez), 32'(eu)});
    check({tag, "_valid"}, {m1_v, m2_v, m3_v, m4_v, mx_v, my_v, mz_v, mu_v}, {8{ev}});
    check({tag, "_busy"}, busy, eb);
  endtask

  initial begin
    xs = 0; ys = 0; zs = 0; u = 0; rotmxx = 0; rotmxy = 0; slope_x = 0; slope_y = 0;
    x0 = 0; y0 = 0; z0 = 0; offset_slew = 0;
    zsrv_m = 0;
    set_z(0, 1'b0);
    model_reset();

    repeat (3) @(negedge a_clk);
    check_reset("por");
    a_resetn = 1'b1;

    // Identity rotation
    rotmxx = 32'h1000_0000; rotmxy = 0; xs = 1000; ys = -500; u = 12345;
    set_z(0, 1'b1);
    run_tick("ident");
    check("ident_x_const", m1_d, 1000);
    check("ident_y_const", m2_d, -500);
    check("ident_u_const", m4_d, 12345);

    // 90 degree rotation, then XY offsets with immediate jump
    rotmxx = 0; rotmxy = 32'h1000_0000; xs = 1000; ys = 0;
    run_tick("rot90");
    check("rot90_x_const", m1_d, 0);
    check("rot90_y_const", m2_d, -1000);
    x0 = 7; y0 = 7;
    run_tick("rot90_off_a");
    run_tick("rot90_off_b");
    check("rot90_off_x_const", m1_d, 7);
    check("rot90_off_y_const", m2_d, -993);

    // Bounded slew 0 -> 250 at 100 per tick
    x0 = 0; y0 = 0; rotmxx = 32'h1000_0000; rotmxy = 0; xs = 0; ys = 0;
    run_tick("slew_settle");
    offset_slew = 100; x0 = 250;
    run_tick("slew1");
    check("slew1_busy_const", busy, 1);
    run_tick("slew2");
    check("slew2_x_const", m1_d, 100);
    check("slew2_busy_const", busy, 1);
    run_tick("slew3");
    check("slew3_x_const", m1_d, 200);
    check("slew3_busy_const", busy, 0);
    run_tick("slew4");
    check("slew4_x_const", m1_d, 250);

    // Z saturation at both rails
    offset_slew = 0; z0 = 32'h7FFF_FFF0; zs = 0;
    set_z(32'sh100, 1'b1);
    run_tick("satp_a");
    run_tick("satp_b");
    check("satp_z_const", m3_d, 64'sh7FFF_FFFF);
    z0 = 32'h8000_0010;
    set_z(-32'sh100, 1'b1);
    run_tick("satn_a");
    run_tick("satn_b");
    check("satn_z_const", m3_d, -64'sh7FFF_FFFF);

    // Plane slope 0.5 on Xr=2000
    z0 = 0; x0 = 0; y0 = 0; xs = 2000; ys = 0; zs = 0;
    slope_x = 32'h0080_0000; slope_y = 0;
    set_z(0, 1'b1);
    run_tick("slope_a");
    run_tick("slope_b");
`ifdef SPM_SCAN_TRANSFORM_SLOPE_EN
    check("slope_z_const", m3_d, 1000);
`else
    check("slope_z_const", m3_d, 0);
`endif

    // Random vectors, including Z-servo holds and partial slews
    for (int n = 0; n < 24; n++) begin
      xs = $urandom; ys = $urandom; zs = $urandom; u = $urandom;
      rotmxx = $urandom; rotmxy = $urandom;
      slope_x = $urandom; slope_y = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        x0 = $urandom; y0 = $urandom; z0 = $urandom;
      end
      offset_slew = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
      set_z($urandom, $urandom_range(0, 2) != 0);
      run_tick("rand");
    end

    // Asynchronous reset mid-slew and mid-pipeline
    rotmxx = 32'h1000_0000; rotmxy = 0; xs = 0; ys = 0; zs = 0; u = 0;
    slope_x = 0; slope_y = 0; x0 = 1000; y0 = 0; z0 = 0; offset_slew = 100;
    set_z(0, 1'b1);
    run_tick("pre_rst");
    run_tick("pre_rst2");
    @(negedge a_clk);
    while (tcnt != {RDECI{1'b1}}) @(negedge a_clk);
    repeat (2) @(posedge a_clk);
    #2 a_resetn = 1'b0;
    #1;
    check_reset("mid_rst");
    model_reset();
    repeat (3) @(negedge a_clk);
    a_resetn = 1'b1;
    run_tick("post_rst1");
    check("post_rst1_x_const", m1_d, 0);
    check("post_rst1_v_const", m1_v, 1);
    run_tick("post_rst2");
    check("post_rst2_x_const", m1_d, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
